// File: rtl/pixel_stream_pkg.sv
// Shared definitions for the raw pixel-stream path: streamer FSM states and the
// default frame geometry also used by line_buffer.
package pixel_stream_pkg;

    localparam int DEF_I_F_BW = 8;
    localparam int DEF_IX     = 28;
    localparam int DEF_IY     = 28;
    localparam int DEF_KX     = 3;
    localparam int DEF_KY     = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        GAP    = 2'd2,
        DONE   = 2'd3
    } fs_state_t;

    // Counter width able to hold 0..value-1, never narrower than one bit.
    function automatic int clog2_min1(input int value);
        return (value < 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/frame_streamer_if.sv
// Pixel/valid/ready stream with row and frame qualifiers, as consumed by line_buffer.
interface frame_streamer_if #(
    parameter int I_F_BW = 8
) ();
    logic              i_ready;
    logic              o_out_valid;
    logic [I_F_BW-1:0] o_out_pixel;
    logic              o_sol;
    logic              o_eol;
    logic              o_sof;
    logic              o_eof;

    modport master (
        input  i_ready,
        output o_out_valid, o_out_pixel, o_sol, o_eol, o_sof, o_eof
    );

    modport slave (
        output i_ready,
        input  o_out_valid, o_out_pixel, o_sol, o_eol, o_sof, o_eof
    );
endinterface

// File: rtl/frame_streamer_ram.sv
// Frame store: one write port and one registered read port, contents never reset.
module frame_ram #(
    parameter int W     = 8,
    parameter int DEPTH = 784,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data_q
);
    logic [W-1:0] mem [DEPTH];

    // Read data only changes on a read, so a stalled pipeline keeps its pixel.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/frame_streamer.sv
// Replays a stored IX x IY frame as a raster-order pixel stream with row/frame flags.
// Optional zero border: define FRAME_STREAMER_ZERO_PAD_EN.
module frame_streamer
    import pixel_stream_pkg::*;
#(
    parameter int I_F_BW   = DEF_I_F_BW,
    parameter int IX       = DEF_IX,
    parameter int IY       = DEF_IY,
    parameter int LINE_GAP = 0,
    parameter int PAD      = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_wr_en,
    input  logic [$clog2(IX*IY)-1:0] i_wr_addr,
    input  logic [I_F_BW-1:0]        i_wr_data,
    input  logic                     i_start,
    frame_streamer_if.master         strm,
    output logic                     o_busy,
    output logic                     o_done
);
`ifdef FRAME_STREAMER_ZERO_PAD_EN
    localparam int PAD_EN = 1;
`else
    localparam int PAD_EN = 0;
`endif
    localparam int OX   = IX + 2 * PAD * PAD_EN;
    localparam int OY   = IY + 2 * PAD * PAD_EN;
    localparam int NPIX = IX * IY;
    localparam int AW   = $clog2(NPIX);
    localparam int XW   = clog2_min1(OX);
    localparam int YW   = clog2_min1(OY);
    localparam int GW   = clog2_min1(LINE_GAP + 1);
    localparam bit GAP_EN = (LINE_GAP > 0);
    localparam logic [XW-1:0] X_LAST   = XW'(OX - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(OY - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((LINE_GAP > 0) ? LINE_GAP - 1 : 0);
    localparam logic [AW:0]   NPIX_W   = (AW + 1)'(NPIX);
`ifdef FRAME_STREAMER_ZERO_PAD_EN
    localparam logic [XW-1:0] X_LO = XW'(PAD);
    localparam logic [XW-1:0] X_HI = XW'(PAD + IX);
    localparam logic [YW-1:0] Y_LO = YW'(PAD);
    localparam logic [YW-1:0] Y_HI = YW'(PAD + IY);
`endif

    fs_state_t         state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              issue_done_q, issue_done_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              s1_valid_q, s1_valid_d;
    logic              s1_sol_q, s1_sol_d, s1_eol_q, s1_eol_d;
    logic              s1_sof_q, s1_sof_d, s1_eof_q, s1_eof_d;
`ifdef FRAME_STREAMER_ZERO_PAD_EN
    logic              s1_zero_q, s1_zero_d;
    logic              interior_s;
`endif
    logic              out_valid_q, out_valid_d;
    logic [I_F_BW-1:0] out_pixel_q, out_pixel_d;
    logic              out_sol_q, out_sol_d, out_eol_q, out_eol_d;
    logic              out_sof_q, out_sof_d, out_eof_q, out_eof_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              accept_s;
    logic              s1_adv_s;
    logic              issue_s;
    logic              rd_en_s;
    logic              wr_ok_s;
    logic [I_F_BW-1:0] rd_data_s;

    // Writes only land while idle and in range, so a streaming frame stays coherent.
    assign wr_ok_s  = i_wr_en && (state_q == IDLE) && ({1'b0, i_wr_addr} < NPIX_W);
    assign accept_s = out_valid_q && strm.i_ready;

    frame_ram #(
        .W     (I_F_BW),
        .DEPTH (NPIX),
        .AW    (AW)
    ) u_ram (
        .clk       (clk),
        .wr_en     (wr_ok_s),
        .wr_addr   (i_wr_addr),
        .wr_data   (i_wr_data),
        .rd_en     (rd_en_s),
        .rd_addr   (addr_q),
        .rd_data_q (rd_data_s)
    );

    // Next-state: FSM, output register, read stage and raster issue counters.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        addr_d       = addr_q;
        issue_done_d = issue_done_q;
        gap_d        = gap_q;
        s1_valid_d   = s1_valid_q;
        s1_sol_d     = s1_sol_q;
        s1_eol_d     = s1_eol_q;
        s1_sof_d     = s1_sof_q;
        s1_eof_d     = s1_eof_q;
        out_valid_d  = out_valid_q;
        out_pixel_d  = out_pixel_q;
        out_sol_d    = out_sol_q;
        out_eol_d    = out_eol_q;
        out_sof_d    = out_sof_q;
        out_eof_d    = out_eof_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        s1_adv_s     = 1'b0;
        issue_s      = 1'b0;
        rd_en_s      = 1'b0;
`ifdef FRAME_STREAMER_ZERO_PAD_EN
        s1_zero_d    = s1_zero_q;
        interior_s   = (x_q >= X_LO) && (x_q < X_HI) && (y_q >= Y_LO) && (y_q < Y_HI);
`endif

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d      = STREAM;
                    busy_d       = 1'b1;
                    x_d          = '0;
                    y_d          = '0;
                    addr_d       = '0;
                    issue_done_d = 1'b0;
                    s1_valid_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            STREAM: begin
                if (accept_s && out_eof_q) begin
                    state_d     = DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    out_valid_d = 1'b0;
                end else if (accept_s && out_eol_q && GAP_EN) begin
                    // The next row's first beat waits in the read stage until the gap ends.
                    state_d     = GAP;
                    gap_d       = '0;
                    out_valid_d = 1'b0;
                end else if (!out_valid_q || accept_s) begin
                    s1_adv_s    = s1_valid_q;
                    out_valid_d = s1_valid_q;
                end else begin
                    out_valid_d = out_valid_q;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d     = STREAM;
                    s1_adv_s    = s1_valid_q;
                    out_valid_d = s1_valid_q;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            DONE: begin
                state_d    = IDLE;
                s1_valid_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (s1_adv_s) begin
            out_sol_d   = s1_sol_q;
            out_eol_d   = s1_eol_q;
            out_sof_d   = s1_sof_q;
            out_eof_d   = s1_eof_q;
`ifdef FRAME_STREAMER_ZERO_PAD_EN
            out_pixel_d = s1_zero_q ? '0 : rd_data_s;
`else
            out_pixel_d = rd_data_s;
`endif
        end else begin
            out_pixel_d = out_pixel_q;
        end

        issue_s = ((state_q == STREAM) || (state_q == GAP)) && !issue_done_q
                  && (!s1_valid_q || s1_adv_s);

        if (issue_s) begin
            s1_valid_d = 1'b1;
            s1_sol_d   = (x_q == '0);
            s1_eol_d   = (x_q == X_LAST);
            s1_sof_d   = (x_q == '0) && (y_q == '0);
            s1_eof_d   = (x_q == X_LAST) && (y_q == Y_LAST);
`ifdef FRAME_STREAMER_ZERO_PAD_EN
            // Border beats skip the RAM; interior beats are sequential in RAM order.
            s1_zero_d = !interior_s;
            rd_en_s   = interior_s;
            if (interior_s) begin
                addr_d = addr_q + 1'b1;
            end else begin
                addr_d = addr_q;
            end
`else
            rd_en_s = 1'b1;
            addr_d  = addr_q + 1'b1;
`endif
            if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q == Y_LAST) begin
                    issue_done_d = 1'b1;
                end else begin
                    y_d = y_q + 1'b1;
                end
            end else begin
                x_d = x_q + 1'b1;
            end
        end else if (s1_adv_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // State and output registers with synchronous reset; RAM is left untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            addr_q       <= '0;
            issue_done_q <= 1'b0;
            gap_q        <= '0;
            s1_valid_q   <= 1'b0;
            s1_sol_q     <= 1'b0;
            s1_eol_q     <= 1'b0;
            s1_sof_q     <= 1'b0;
            s1_eof_q     <= 1'b0;
`ifdef FRAME_STREAMER_ZERO_PAD_EN
            s1_zero_q    <= 1'b0;
`endif
            out_valid_q  <= 1'b0;
            out_pixel_q  <= '0;
            out_sol_q    <= 1'b0;
            out_eol_q    <= 1'b0;
            out_sof_q    <= 1'b0;
            out_eof_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            addr_q       <= addr_d;
            issue_done_q <= issue_done_d;
            gap_q        <= gap_d;
            s1_valid_q   <= s1_valid_d;
            s1_sol_q     <= s1_sol_d;
            s1_eol_q     <= s1_eol_d;
            s1_sof_q     <= s1_sof_d;
            s1_eof_q     <= s1_eof_d;
`ifdef FRAME_STREAMER_ZERO_PAD_EN
            s1_zero_q    <= s1_zero_d;
`endif
            out_valid_q  <= out_valid_d;
            out_pixel_q  <= out_pixel_d;
            out_sol_q    <= out_sol_d;
            out_eol_q    <= out_eol_d;
            out_sof_q    <= out_sof_d;
            out_eof_q    <= out_eof_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign strm.o_out_valid = out_valid_q;
    assign strm.o_out_pixel = out_pixel_q;
    assign strm.o_sol       = out_sol_q;
    assign strm.o_eol       = out_eol_q;
    assign strm.o_sof       = out_sof_q;
    assign strm.o_eof       = out_eof_q;
    assign o_busy           = busy_q;
    assign o_done           = done_q;
endmodule

// File: tb/tb_frame_streamer.sv
// Self-checking bench for frame_streamer: a back-to-back instance and a LINE_GAP=3
// instance, checked against a raster-order reference model of the stored frame.
module tb_frame_streamer;
    import pixel_stream_pkg::*;

    localparam int IX    = 28;
    localparam int IY    = 28;
    localparam int BW    = 8;
    localparam int AW    = $clog2(IX * IY);
    localparam int GAP_B = 3;
`ifdef FRAME_STREAMER_ZERO_PAD_EN
    localparam int PADW  = 2;
`else
    localparam int PADW  = 0;
`endif
    localparam int OX     = IX + 2 * PADW;
    localparam int OY     = IY + 2 * PADW;
    localparam int NBEAT  = OX * OY;
    localparam int BUDGET = 6000;

    typedef struct packed {
        logic          valid;
        logic [BW-1:0] pix;
        logic          sol;
        logic          eol;
        logic          sof;
        logic          eof;
    } beat_t;

    typedef struct {
        int dut;      // 0: LINE_GAP=0, 1: LINE_GAP=GAP_B
        int mode;     // ready: 0 always, 1 pattern 1,0,0,1, 2 random
        int load;     // 0 keep RAM, 1 ramp a[7:0], 2 random
        bit poke;     // start + write addr 0 while busy
        bit sad;      // start in the o_done cycle
        int span;     // first-valid..eof cycles, -1 unchecked
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic wr_en_a, wr_en_b;
    logic [AW-1:0] wr_addr;
    logic [BW-1:0] wr_data;
    logic start_a, start_b;
    logic busy_a, busy_b, done_a, done_b;
    logic [BW-1:0] mem_model [IX*IY];
    int checks;
    int failures;

    frame_streamer_if #(.I_F_BW(BW)) sa ();
    frame_streamer_if #(.I_F_BW(BW)) sb ();

    frame_streamer #(.I_F_BW(BW), .IX(IX), .IY(IY), .LINE_GAP(0), .PAD(2)) dut_a (
        .clk(clk), .reset(reset), .i_wr_en(wr_en_a), .i_wr_addr(wr_addr),
        .i_wr_data(wr_data), .i_start(start_a), .strm(sa), .o_busy(busy_a), .o_done(done_a)
    );

    frame_streamer #(.I_F_BW(BW), .IX(IX), .IY(IY), .LINE_GAP(GAP_B), .PAD(2)) dut_b (
        .clk(clk), .reset(reset), .i_wr_en(wr_en_b), .i_wr_addr(wr_addr),
        .i_wr_data(wr_data), .i_start(start_b), .strm(sb), .o_busy(busy_b), .o_done(done_b)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic beat_t sample(input int d);
        beat_t b;
        if (d == 0) b = '{sa.o_out_valid, sa.o_out_pixel, sa.o_sol, sa.o_eol, sa.o_sof, sa.o_eof};
        else        b = '{sb.o_out_valid, sb.o_out_pixel, sb.o_sol, sb.o_eol, sb.o_sof, sb.o_eof};
        return b;
    endfunction

    function automatic int outs_of(input int d);
        beat_t b;
        b = sample(d);
        return (d == 0) ? int'({b, busy_a, done_a}) : int'({b, busy_b, done_b});
    endfunction

    // Reference: beat n is raster position (n % OX, n / OX) of the (padded) frame.
    function automatic beat_t exp_beat(input int n);
        beat_t b;
        int x, y;
        x = n % OX;
        y = n / OX;
        b.valid = 1'b1;
        if (x >= PADW && x < PADW + IX && y >= PADW && y < PADW + IY)
            b.pix = mem_model[(y - PADW) * IX + (x - PADW)];
        else
            b.pix = '0;
        b.sol = (x == 0);
        b.eol = (x == OX - 1);
        b.sof = (n == 0);
        b.eof = (n == NBEAT - 1);
        return b;
    endfunction

    function automatic logic ready_val(input int mode, input int c);
        logic [3:0] pat;
        pat = 4'b1001;
        if (mode == 0) return 1'b1;
        if (mode == 1) return pat[3 - (c % 4)];
        return ($urandom_range(0, 3) != 0);
    endfunction

    task automatic set_ready(input int d, input logic r);
        if (d == 0) sa.i_ready = r;
        else        sb.i_ready = r;
    endtask

    task automatic set_start(input int d);
        if (d == 0) start_a = 1'b1;
        else        start_b = 1'b1;
    endtask

    task automatic load_ram(input int kind);
        for (int a = 0; a < IX * IY; a++) begin
            @(negedge clk);
            wr_en_a = 1'b1;
            wr_en_b = 1'b1;
            wr_addr = AW'(a);
            wr_data = (kind == 1) ? BW'(a) : BW'($urandom_range(0, 255));
            mem_model[a] = wr_data;
        end
        @(negedge clk);
        wr_addr = AW'(IX * IY);
        wr_data = 8'h5A;
        @(negedge clk);
        wr_en_a = 1'b0;
        wr_en_b = 1'b0;
    endtask

    task automatic run_frame(input int d, input int mode, input bit poke, input bit sad,
                             input int span);
        int k, cyc, first_v, eof_c, done_c, done_n, busy_err, bubbles, gap;
        logic rdy, busy, prev_hold;
        beat_t cur, prev, e;
        k = 0; first_v = -1; eof_c = -1; done_c = -1; done_n = 0;
        busy_err = 0; bubbles = 0; prev_hold = 1'b0; prev = '0;
        gap = (d == 0) ? 0 : GAP_B;
        @(negedge clk);
        set_start(d);
        set_ready(d, ready_val(mode, 0));
        cyc = 0;
        while (cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            start_a = 1'b0;
            start_b = 1'b0;
            wr_en_a = 1'b0;
            cur = sample(d);
            if (prev_hold) check_eq("hold_stable", int'(cur), int'(prev));
            busy = (d == 0) ? busy_a : busy_b;
            if (busy !== (eof_c < 0)) busy_err++;
            if ((d == 0) ? done_a : done_b) begin
                done_n++;
                done_c = cyc;
                if (sad) set_start(d);
            end
            if (poke && cyc == 40) begin
                set_start(d);
                wr_en_a = 1'b1;
                wr_addr = '0;
                wr_data = 8'hFF;
            end
            rdy = ready_val(mode, cyc);
            set_ready(d, rdy);
            if (cur.valid) begin
                if (first_v < 0) first_v = cyc;
                if (rdy) begin
                    if (k < NBEAT) begin
                        e = exp_beat(k);
                        check_eq($sformatf("beat%0d", k), int'(cur), int'(e));
                        if (mode == 0 && k > 0)
                            check_eq($sformatf("bubbles_before%0d", k), bubbles,
                                     exp_beat(k - 1).eol ? gap : 0);
                        if (k == NBEAT - 1) eof_c = cyc;
                    end else begin
                        check_eq("extra_beat", k, NBEAT - 1);
                    end
                    k++;
                    bubbles = 0;
                end
            end else begin
                bubbles++;
            end
            prev_hold = cur.valid && !rdy;
            prev = cur;
            if (done_c >= 0 && cyc >= done_c + 4) break;
        end
        if (done_c < 0) $display("FAIL frame_timeout dut=%0d beats=%0d required=%0d", d, k, NBEAT);
        check_eq("beat_count", k, NBEAT);
        check_eq("first_valid_latency", first_v, 3);
        check_eq("done_pulses", done_n, 1);
        check_eq("done_after_eof", done_c - eof_c, 1);
        check_eq("busy_window_errors", busy_err, 0);
        if (span > 0) check_eq("stream_span", eof_c - first_v + 1, span);
    endtask

    initial begin
        vec_t vecs [6];
        int cnt, g;
        vecs[0] = '{0, 0, 1, 1'b0, 1'b0, NBEAT};
        vecs[1] = '{0, 1, 0, 1'b0, 1'b0, -1};
        vecs[2] = '{1, 0, 0, 1'b0, 1'b0, NBEAT + (OY - 1) * GAP_B};
        vecs[3] = '{0, 2, 2, 1'b1, 1'b0, -1};
        vecs[4] = '{0, 0, 0, 1'b0, 1'b1, NBEAT};
        vecs[5] = '{1, 2, 2, 1'b0, 1'b0, -1};

        checks = 0;
        failures = 0;
        reset = 1'b1;
        wr_en_a = 1'b0;
        wr_en_b = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start_a = 1'b0;
        start_b = 1'b0;
        sa.i_ready = 1'b1;
        sb.i_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("reset_state_a", outs_of(0), 0);
        check_eq("reset_state_b", outs_of(1), 0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].load != 0) load_ram(vecs[i].load);
            run_frame(vecs[i].dut, vecs[i].mode, vecs[i].poke, vecs[i].sad, vecs[i].span);
            repeat (2) @(negedge clk);
        end

        // Reset in the middle of a frame, then a clean restart from pixel 0.
        @(negedge clk);
        start_a = 1'b1;
        sa.i_ready = 1'b1;
        cnt = 0;
        g = 0;
        while (cnt < 100 && g < 1000) begin
            @(negedge clk);
            start_a = 1'b0;
            g++;
            if (sa.o_out_valid) cnt++;
        end
        check_eq("reset_beat_reached", cnt, 100);
        reset = 1'b1;
        @(negedge clk);
        check_eq("midframe_reset_outputs", outs_of(0), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("idle_after_reset", outs_of(0), 0);
        run_frame(0, 0, 1'b0, 1'b0, NBEAT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
